// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready handshake; define ALU_MC_FAST_MUL_EN for single-cycle MUL
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);
  localparam int H = WIDTH / 2;
  localparam logic [4:0] ALUOP_MOV  = 5'd0;
  localparam logic [4:0] ALUOP_MOVL = 5'd1;
  localparam logic [4:0] ALUOP_MOVH = 5'd2;
  localparam logic [4:0] ALUOP_ADD  = 5'd3;
  localparam logic [4:0] ALUOP_SUB  = 5'd4;
  localparam logic [4:0] ALUOP_MUL  = 5'd5;
  localparam logic [4:0] ALUOP_DIV  = 5'd6;
  localparam logic [4:0] ALUOP_AND  = 5'd7;
  localparam logic [4:0] ALUOP_OR   = 5'd8;
  localparam logic [4:0] ALUOP_XOR  = 5'd9;
  localparam logic [4:0] ALUOP_NOT  = 5'd10;
  localparam logic [4:0] ALUOP_SHL  = 5'd11;
  localparam logic [4:0] ALUOP_SHR  = 5'd12;
  localparam logic [4:0] ALUOP_ASR  = 5'd13;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
`ifdef ALU_MC_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [SHW-1:0] cnt;
  logic is_div;
  logic [WIDTH-1:0] a, b, acc, a_nx, b_nx, acc_nx, op_res;
  logic [WIDTH:0] rs, diff;
  logic [SHW-1:0] sh;
  logic is_iter, op_dz;
  assign sh = val2[SHW-1:0];
  assign op_dz = aluop == ALUOP_DIV && val2 == '0;
  assign is_iter = (aluop == ALUOP_DIV && !op_dz) || (aluop == ALUOP_MUL && !FAST_MUL);
  always_comb begin
    op_res = '0;
    case (aluop)
      ALUOP_MOV:  op_res = val1;
      ALUOP_MOVL: op_res = {{(WIDTH-H){1'b0}}, val2[H-1:0]};
      ALUOP_MOVH: op_res = {{H{1'b0}}, val2[WIDTH-1:H]};
      ALUOP_ADD:  op_res = val1 + val2;
      ALUOP_SUB:  op_res = val1 - val2;
      ALUOP_MUL:  op_res = FAST_MUL ? val1 * val2 : '0;
      ALUOP_DIV:  op_res = '1;
      ALUOP_AND:  op_res = val1 & val2;
      ALUOP_OR:   op_res = val1 | val2;
      ALUOP_XOR:  op_res = val1 ^ val2;
      ALUOP_NOT:  op_res = ~val1;
      ALUOP_SHL:  op_res = val1 << sh;
      ALUOP_SHR:  op_res = val1 >> sh;
      ALUOP_ASR:  op_res = $unsigned($signed(val1) >>> sh);
      default:    op_res = '0;
    endcase
  end
  // Divide: acc is the partial remainder, a shifts the dividend out and the quotient in.
  assign rs = {acc, a[WIDTH-1]};
  assign diff = rs - {1'b0, b};
  assign a_nx = is_div ? {a[WIDTH-2:0], ~diff[WIDTH]} : a << 1;
  assign b_nx = is_div ? b : b >> 1;
  assign acc_nx = is_div ? (diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0]) : acc + (b[0] ? a : '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      result <= '0;
      div_zero <= 1'b0;
      cnt <= '0;
      is_div <= 1'b0;
      a <= '0;
      b <= '0;
      acc <= '0;
    end else if (flush) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          is_div <= aluop == ALUOP_DIV;
          a <= val1;
          b <= val2;
          acc <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= is_iter ? BUSY : DONE;
          out_valid <= !is_iter;
          if (!is_iter) begin
            result <= op_res;
            div_zero <= op_dz;
          end
        end
        BUSY: begin
          a <= a_nx;
          b <= b_nx;
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= is_div ? a_nx : acc_nx;
            div_zero <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc against an arithmetic reference model
module tb_alu_mc;
  localparam logic [4:0] MOV = 5'd0, MOVL = 5'd1, MOVH = 5'd2, ADD = 5'd3, SUB = 5'd4, MUL = 5'd5, DIV = 5'd6;
  localparam logic [4:0] AND_ = 5'd7, OR_ = 5'd8, XOR_ = 5'd9, NOT_ = 5'd10, SHL = 5'd11, SHR = 5'd12, ASR = 5'd13;
`ifdef ALU_MC_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_zero;
  logic [4:0] aluop = '0;
  logic [31:0] val1 = '0, val2 = '0, result;
  int nvec = 0, nerr = 0;
  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
    .val1(val1), .val2(val2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      MOV:  return x;
      MOVL: return y % 32'h1_0000;
      MOVH: return y / 32'h1_0000;
      ADD:  return x + y;
      SUB:  return x - y;
      MUL:  return x * y;
      DIV:  return y == 0 ? 32'hFFFF_FFFF : x / y;
      AND_: return x & y;
      OR_:  return x | y;
      XOR_: return x ^ y;
      NOT_: return ~x;
      SHL:  return x << y[4:0];
      SHR:  return x >> y[4:0];
      ASR:  return $unsigned($signed(x) >>> y[4:0]);
      default: return 32'h0;
    endcase
  endfunction
  function automatic int model_lat(input logic [4:0] op, input logic [31:0] y);
    return (op == DIV && y != 0) ? 32 : (op == MUL ? MUL_LAT : 0);
  endfunction
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic dz, output int lat, output logic rdy_hi);
    aluop = op; val1 = x; val2 = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0; rdy_hi = in_ready;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) rdy_hi |= in_ready;
    end
    r = result; dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (result !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 0", result); end
    nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_add;
    logic [31:0] r; logic dz, rh; int lat;
    run_op(ADD, 32'hFFFF_FFFF, 32'h1, r, dz, lat, rh);
    nvec++; if (r !== 32'h0) begin nerr++; $display("FAIL add_wrap got %h want 0", r); end
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL add_latency got %0d want 0", lat); end
    nvec++; if (dz !== 1'b0) begin nerr++; $display("FAIL add_div_zero got %b want 0", dz); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL add_idle_ready got %b want 1", in_ready); end
  endtask
  task automatic test_mul;
    logic [31:0] r; logic dz, rh; int lat;
    run_op(MUL, 32'h0001_0003, 32'h5, r, dz, lat, rh);
    nvec++; if (r !== 32'h0005_000F) begin nerr++; $display("FAIL mul_res got %h want 0005000f", r); end
    nvec++; if (lat !== MUL_LAT) begin nerr++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
    nvec++; if (rh !== 1'b0) begin nerr++; $display("FAIL mul_busy_ready got %b want 0", rh); end
  endtask
  task automatic test_div;
    logic [31:0] r; logic dz, rh; int lat;
    run_op(DIV, 32'd100, 32'd7, r, dz, lat, rh);
    nvec++; if (r !== 32'd14) begin nerr++; $display("FAIL div_res got %0d want 14", r); end
    nvec++; if (lat !== 32) begin nerr++; $display("FAIL div_latency got %0d want 32", lat); end
    nvec++; if (dz !== 1'b0) begin nerr++; $display("FAIL div_dz got %b want 0", dz); end
    run_op(DIV, 32'd5, 32'd0, r, dz, lat, rh);
    nvec++; if (r !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div0_res got %h want ffffffff", r); end
    nvec++; if (lat !== 0) begin nerr++; $display("FAIL div0_latency got %0d want 0", lat); end
    nvec++; if (dz !== 1'b1) begin nerr++; $display("FAIL div0_dz got %b want 1", dz); end
  endtask
  task automatic test_reset_mid;
    aluop = MUL; val1 = 32'h1234_5678; val2 = 32'h9ABC_DEF1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    nvec++; if (result !== 32'h0) begin nerr++; $display("FAIL midrst_result got %h want 0", result); end
    nvec++; if (div_zero !== 1'b0) begin nerr++; $display("FAIL midrst_div_zero got %b want 0", div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure;
    int waited = 0;
    aluop = ASR; val1 = 32'h8000_0000; val2 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && waited < 100) begin @(posedge clk); #1; waited++; end
    for (int i = 0; i < 5; i++) begin
      nvec++; if (result !== 32'hF800_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        nerr++; $display("FAIL bp_hold[%0d] got res=%h ov=%b ir=%b want f8000000/1/0", i, result, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL bp_release got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
  endtask
  task automatic test_flush;
    logic [31:0] r; logic dz, rh, pulse = 1'b0; int lat;
    aluop = DIV; val1 = 32'd100; val2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL flush_busy got ir=%b want 0", in_ready); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_idle got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
    repeat (30) begin @(posedge clk); #1; pulse |= out_valid; end
    nvec++; if (pulse !== 1'b0) begin nerr++; $display("FAIL flush_no_pulse got %b want 0", pulse); end
    aluop = ADD; val1 = 32'd1; val2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_reject got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
    run_op(MOVH, 32'h0, 32'hABCD_1234, r, dz, lat, rh);
    nvec++; if (r !== 32'h0000_ABCD) begin nerr++; $display("FAIL movh_res got %h want 0000abcd", r); end
  endtask
  task automatic test_misc;
    logic [31:0] r; logic dz, rh; int lat;
    run_op(NOT_, 32'h0000_00F0, 32'h0, r, dz, lat, rh);
    nvec++; if (r !== 32'hFFFF_FF0F) begin nerr++; $display("FAIL not_res got %h want ffffff0f", r); end
    run_op(5'd31, 32'hDEAD_BEEF, 32'h1234_5678, r, dz, lat, rh);
    nvec++; if (r !== 32'h0 || lat !== 0 || dz !== 1'b0) begin
      nerr++; $display("FAIL undef_op got res=%h lat=%0d dz=%b want 0/0/0", r, lat, dz);
    end
    run_op(SHL, 32'hCAFE_F00D, 32'h20, r, dz, lat, rh);
    nvec++; if (r !== 32'hCAFE_F00D) begin nerr++; $display("FAIL shift0_res got %h want cafef00d", r); end
  endtask
  task automatic test_random;
    logic [31:0] r, x, y; logic dz, rh; int lat; logic [4:0] op;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(op, x, y, r, dz, lat, rh);
      nvec++; if (r !== model(op, x, y)) begin
        nerr++; $display("FAIL rand_res[%0d] op=%0d x=%h y=%h got %h want %h", i, op, x, y, r, model(op, x, y));
      end
      nvec++; if (lat !== model_lat(op, y)) begin
        nerr++; $display("FAIL rand_lat[%0d] op=%0d got %0d want %0d", i, op, lat, model_lat(op, y));
      end
      nvec++; if (dz !== (op == DIV && y == 0)) begin
        nerr++; $display("FAIL rand_dz[%0d] op=%0d got %b want %b", i, op, dz, op == DIV && y == 0);
      end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_reset_mid;
    test_backpressure;
    test_flush;
    test_misc;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
